// File: rtl/trace_pkg.sv
// Shared types and constants for the CPU trace transmit path.
// A record is four 32-bit words, sent in the order cyc, pc, stall count, flush count.
package trace_pkg;

  localparam int REC_WORDS = 4;

  localparam logic [1:0] W_CYC   = 2'd0;
  localparam logic [1:0] W_PC    = 2'd1;
  localparam logic [1:0] W_STALL = 2'd2;
  localparam logic [1:0] W_FLUSH = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W0,
    ST_W1,
    ST_W2,
    ST_W3
  } state_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] pc;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
  } rec_t;

  function automatic logic [1:0] state_word(input state_t s);
    case (s)
      ST_W1:   return W_PC;
      ST_W2:   return W_STALL;
      ST_W3:   return W_FLUSH;
      default: return W_CYC;
    endcase
  endfunction

  function automatic logic [31:0] rec_word(input rec_t rec, input logic [1:0] sel);
    case (sel)
      W_CYC:   return rec.cyc;
      W_PC:    return rec.pc;
      W_STALL: return rec.stall_cnt;
      default: return rec.flush_cnt;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_trace_tx_if.sv
// Word-stream valid/ready channel from the trace transmitter to its log sink.
interface pipeline_trace_tx_if;

  logic        m_valid_o;
  logic        m_ready_i;
  logic [31:0] m_data_o;
  logic        m_last_o;

  modport master (
    output m_valid_o,
    output m_data_o,
    output m_last_o,
    input  m_ready_i
  );

  modport slave (
    input  m_valid_o,
    input  m_data_o,
    input  m_last_o,
    output m_ready_i
  );

endinterface

// File: rtl/trace_fifo.sv
// Record FIFO for the trace path; a push into a full FIFO is taken only
// when the head is popped on the same edge.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  rec_t                     din,
  output rec_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          wr_en;
  logic          rd_en;
  rec_t          mem [DEPTH];

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign count = cnt;
  assign dout  = mem[rd_ptr];
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: the counters decide which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pipeline_trace_tx.sv
// Samples CPU pipeline status each running cycle into 4-word records and
// streams them out over a registered 32-bit valid/ready channel.
module pipeline_trace_tx
  import trace_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [31:0]          pc_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  pipeline_trace_tx_if.master  m,
  output logic [DROP_W-1:0]    drop_cnt_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]       cyc;
  logic [31:0]       stall_cnt;
  logic [31:0]       flush_cnt;
  logic [31:0]       cyc_next;
  logic [31:0]       stall_next;
  logic [31:0]       flush_next;
  logic [DROP_W-1:0] drop_cnt;
  rec_t              new_rec;
  rec_t              head;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              hs;
  logic              pop;
  logic              push;
  logic              drop;
  logic              valid;
  state_t            state;
  state_t            state_next;

  always_comb begin
    cyc_next   = cyc + 32'd1;
    stall_next = stall_cnt + {31'd0, stall_i};
    flush_next = flush_cnt + {31'd0, flush_i};
    new_rec    = '{cyc: cyc_next, pc: pc_i, stall_cnt: stall_next, flush_cnt: flush_next};
  end

  // The slot freed by popping the head on this edge may be refilled on the same edge.
  assign valid = (state != ST_IDLE);
  assign hs    = valid && m.m_ready_i;
  assign pop   = hs && (state == ST_W3);
  assign push  = start_i && (!full || pop);
  assign drop  = start_i && full && !pop;

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .push  (push),
    .pop   (pop),
    .din   (new_rec),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cyc       <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (start_i) begin
      cyc       <= cyc_next;
      stall_cnt <= stall_next;
      flush_cnt <= flush_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != {DROP_W{1'b1}})) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Entering W0 on the push edge itself gives one-cycle capture-to-valid latency.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (push || !empty) state_next = ST_W0;
      ST_W0:   if (hs) state_next = ST_W1;
      ST_W1:   if (hs) state_next = ST_W2;
      ST_W2:   if (hs) state_next = ST_W3;
      ST_W3:   if (hs) state_next = ((count > CW'(1)) || push) ? ST_W0 : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign m.m_valid_o = valid;
  assign m.m_last_o  = (state == ST_W3);
  assign m.m_data_o  = valid ? rec_word(head, state_word(state)) : 32'd0;
  assign drop_cnt_o  = drop_cnt;
  assign busy_o      = valid || !empty;

endmodule
